// File: rtl/l2sw_pkg.sv
// Shared L2 switch definitions: word layout, end-of-frame detection and the
// transmit-arbiter state encoding.
package l2sw_pkg;

  localparam int         WORD_W    = 72;
  localparam logic [7:0] MASK_FULL = 8'hFF;

  typedef enum logic {
    IDLE,
    XFER
  } arb_state_t;

  // Any partial byte-valid mask, including the 8'h00 terminator, closes a frame.
  function automatic logic is_eof(input logic [7:0] mask);
    return mask != MASK_FULL;
  endfunction

endpackage

// File: rtl/tx_port_arbiter_if.sv
// Queue-side and consumer-side FWFT handshake bundle for one TX arbiter.
// master is the arbiter, slave is the surrounding queues plus the consumer.
interface tx_port_arbiter_if #(
  parameter int NPORT = 4
);
  import l2sw_pkg::*;

  logic [WORD_W*NPORT-1:0] in_dout;
  logic [NPORT-1:0]        in_empty;
  logic [NPORT-1:0]        in_rd_en;
  logic [WORD_W-1:0]       out_dout;
  logic                    out_empty;
  logic                    out_rd_en;

  modport master (
    input  in_dout, in_empty, out_rd_en,
    output in_rd_en, out_dout, out_empty
  );

  modport slave (
    output in_dout, in_empty, out_rd_en,
    input  in_rd_en, out_dout, out_empty
  );

endinterface

// File: rtl/tx_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible queue strictly after
// `last`, wrapping, as a one-hot winner plus a valid flag.
module rr_pick #(
  parameter  int NPORT = 4,
  localparam int IDX_W = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] eligible,
  input  logic [IDX_W-1:0] last,
  output logic [NPORT-1:0] winner,
  output logic             valid
);

  always_comb begin : pick_proc
    logic [IDX_W-1:0] idx;
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NPORT; k++) begin
      idx = IDX_W'((int'(last) + k) % NPORT);
      if (!valid && eligible[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_port_arbiter.sv
// Frame-granular round-robin arbiter feeding one XGMII TX path from up to four
// RX queues. Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module tx_port_arbiter
  import l2sw_pkg::*;
#(
  parameter int          NPORT       = 4,
  parameter logic [15:0] STALL_LIMIT = 16'd1024
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  tx_port_arbiter_if.master    bus,
  input  logic [NPORT-1:0]     port_en,
  output logic [NPORT-1:0]     grant,
  output logic [16*NPORT-1:0]  frame_cnt
`ifdef ARB_WATCHDOG_EN
  ,
  output logic [NPORT-1:0]     stall_err
`endif
);

  localparam int IDX_W = $clog2(NPORT);

  arb_state_t        state_reg;
  logic [NPORT-1:0]  grant_reg;
  logic [IDX_W-1:0]  gidx_reg;
  logic [IDX_W-1:0]  last_reg;
  logic [15:0]       frame_cnt_reg [NPORT];

  logic [WORD_W-1:0] lane [NPORT];
  logic [NPORT-1:0]  eligible;
  logic [NPORT-1:0]  pick_onehot;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [WORD_W-1:0] sel_word;
  logic              sel_empty;
  logic              xfer;
  logic              pop;

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_lane
      assign lane[gi]                 = bus.in_dout[WORD_W*gi +: WORD_W];
      assign frame_cnt[16*gi +: 16]   = frame_cnt_reg[gi];
    end
  endgenerate

`ifdef ARB_WATCHDOG_EN
  logic [15:0]      stall_cnt_reg;
  logic [NPORT-1:0] stall_err_reg;

  assign stall_err = stall_err_reg;
  assign eligible  = port_en & ~bus.in_empty & ~stall_err_reg;
`else
  assign eligible  = port_en & ~bus.in_empty;
`endif

  rr_pick #(
    .NPORT (NPORT)
  ) u_rr_pick (
    .eligible (eligible),
    .last     (last_reg),
    .winner   (pick_onehot),
    .valid    (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (pick_onehot[i]) pick_idx = IDX_W'(i);
    end
  end

  // Data path is a pure mux on the registered owner: no added latency.
  assign xfer          = (state_reg == XFER);
  assign sel_word      = lane[gidx_reg];
  assign sel_empty     = bus.in_empty[gidx_reg];
  assign pop           = xfer & bus.out_rd_en & ~sel_empty;
  assign bus.out_dout  = xfer ? sel_word : '0;
  assign bus.out_empty = xfer ? sel_empty : 1'b1;
  assign bus.in_rd_en  = pop ? grant_reg : '0;
  assign grant         = grant_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      last_reg  <= IDX_W'(NPORT - 1);
      for (int i = 0; i < NPORT; i++) frame_cnt_reg[i] <= '0;
`ifdef ARB_WATCHDOG_EN
      stall_cnt_reg <= '0;
      stall_err_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            state_reg <= XFER;
            grant_reg <= pick_onehot;
            gidx_reg  <= pick_idx;
          end
`ifdef ARB_WATCHDOG_EN
          stall_cnt_reg <= '0;
`endif
        end
        XFER: begin
          if (pop && is_eof(sel_word[WORD_W-1 -: 8])) begin
            frame_cnt_reg[gidx_reg] <= frame_cnt_reg[gidx_reg] + 16'd1;
            last_reg  <= gidx_reg;
            grant_reg <= '0;
            state_reg <= IDLE;
          end
`ifdef ARB_WATCHDOG_EN
          // A stalled owner is dropped without counting its partial frame.
          if (!sel_empty) begin
            stall_cnt_reg <= '0;
          end else if (stall_cnt_reg == STALL_LIMIT - 16'd1) begin
            stall_err_reg[gidx_reg] <= 1'b1;
            stall_cnt_reg <= '0;
            last_reg      <= gidx_reg;
            grant_reg     <= '0;
            state_reg     <= IDLE;
          end else begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_port_arbiter.md
# tx_port_arbiter

Frame-granular round-robin arbiter that lets one XGMII transmit path (`fifo72toxgmii` read side) take frames from up to four RX PHY queues. It replaces the fixed port-0↔port-1 cross-connect in `l2switch`: one instance per TX port, with inputs from the other ports' `rxN_phyq` FIFOs. A frame is never interleaved; grants change only on frame boundaries.

## Interface
Parameters:
- `NPORT`, 4: number of requesting queues (2..4).
- `STALL_LIMIT`, 16'd1024: cycles a granted queue may stay empty mid-frame before the watchdog fires.

Ports:
- `sys_clk`, in, 1: single clock for the whole block.
- `sys_rst`, in, 1: reset, synchronous and active-high.
- `in_dout`, in, 72*NPORT: queue data, slice i = `[72*i+71:72*i]`; FWFT (data valid while not empty).
- `in_empty`, in, NPORT: queue empty flags.
- `in_rd_en`, out, NPORT: queue pop strobes.
- `out_dout`, out, 72: data toward `fifo72toxgmii`.
- `out_empty`, out, 1: high when no granted word is available.
- `out_rd_en`, in, 1: consumer pop strobe.
- `port_en`, in, NPORT: static enable mask; disabled queues are never granted.
- `grant`, out, NPORT: one-hot current owner, 0 when idle.
- `frame_cnt`, out, 16*NPORT: per-queue count of completed frames, wraps at 16'hFFFF→0.
- `stall_err`, out, NPORT: sticky watchdog flags; only present with `ARB_WATCHDOG_EN`.

## Operation
- Word format: `[71:64]` is the byte-valid mask and `[63:0]` is the data. A word is end-of-frame (EOF) when its mask != 8'hFF. Frames of length 8n end with a mask 8'h00 terminator word.
- States:
  - IDLE: `grant`=0, `out_empty`=1. If any eligible queue is non-empty, go to XFER and register `grant` to the first eligible queue after `last` in round-robin order. A queue is eligible when `port_en` is set and `!in_empty`; with `ARB_WATCHDOG_EN` it must also have `!stall_err`.
  - XFER: `out_dout`=`in_dout[grant]`, `out_empty`=`in_empty[grant]`, `in_rd_en[grant]`=`out_rd_en & !in_empty[grant]`, and all other `in_rd_en` are 0.
    - On a pop of an EOF word: `frame_cnt[grant]`++, `last`←grant, next state IDLE.
  - Pops with `out_rd_en` while `out_empty`=1 are ignored and no underflow is propagated.
- `last` resets to NPORT-1, so queue 0 wins first.
- Simultaneous requests are resolved purely by round-robin from `last`+1.
- Clearing `port_en` mid-frame does not revoke the grant; it takes effect at the next IDLE arbitration.
- Reset mid-frame: state goes to IDLE and counters clear. A partially read frame in the upstream FIFO is not flushed by this block.

## Timing
- Reset values: `grant`=0, `out_empty`=1, `in_rd_en`=0, `out_dout`=72'h0 (muxed to zero while idle), `frame_cnt`=0, `stall_err`=0, `last`=NPORT-1.
- Request latency: a queue that goes non-empty in cycle t while IDLE has `grant` set and `out_empty`=0 in cycle t+1.
- Frame gap: after the EOF pop in cycle t, the block is IDLE in t+1 (out_empty=1). The next grant is visible in t+2, so there is one bubble cycle per frame.
- Path: `out_dout`, `out_empty` and `in_rd_en` are combinational from registered `grant` and the inputs. No added data latency.
- `frame_cnt` updates in the cycle after the EOF pop.

## Configuration
- `ARB_WATCHDOG_EN` defined:
  - A 16-bit counter runs in XFER while `in_empty[grant]`=1 and clears on any non-empty cycle.
  - When it reaches STALL_LIMIT: set `stall_err[grant]`, go to IDLE with `last`←grant, and do not increment `frame_cnt`.
  - A flagged queue stays ineligible until `sys_rst`.
- Undefined: no counter and no `stall_err` port. XFER waits indefinitely for EOF.

## Structure
- Shared package `l2sw_pkg`: `WORD_W`=72, `MASK_FULL`=8'hFF, the EOF-detect function, and the state enum (IDLE, XFER).
- Sub-module `rr_pick`: combinational round-robin picker, with inputs eligible vector and `last` and output one-hot winner plus valid.

## Test plan
- Single frame: queue 0 holds 3 words with masks FF, FF, 0F and the consumer pops continuously → `grant`=0001 from t+1, three words out in order, IDLE after the third, `frame_cnt[0]`=1.
- Contention: queues 0–3 each hold one 2-word frame → grant order 0,1,2,3, one bubble between frames, no interleaving, and each `frame_cnt`=1.
- Fairness: queues 1 and 2 are continuously backlogged → grants alternate 1,2,1,2 for 10 frames.
- Mask: `port_en`=4'b1101 with queue 1 full → queue 1 is never granted and `in_rd_en[1]` stays 0. Setting bit 1 → it is served in the next round.
- 8n frame: a frame with masks FF, FF, 00 → release only after the 00 terminator is popped.
- Watchdog (`ARB_WATCHDOG_EN`, STALL_LIMIT=8): queue 2 supplies 1 of 2 words then runs empty → `stall_err[2]`=1 after 8 empty cycles, IDLE, and queue 2 is skipped thereafter. `sys_rst` clears it.
